// File: rtl/lzrw1_decompressor_stream.sv
// Streaming LZRW1 decompressor: expands literal/copy items into a byte stream
// through a circular history window, with block framing and copy bounds checks.
module lzrw1_decompressor_stream #(
    parameter  int HISTORY_DEPTH = 4096,
    parameter  int OFFSET_WIDTH  = 12,
    parameter  int LENGTH_WIDTH  = 4,
    parameter  int COUNT_WIDTH   = 16,
    localparam int DATA_WIDTH    = OFFSET_WIDTH + LENGTH_WIDTH
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic                   block_start,
    input  logic [DATA_WIDTH-1:0]  data_in,
    input  logic                   control_word_in,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [7:0]             out_byte,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   busy,
    output logic                   error,
    output logic [COUNT_WIDTH-1:0] bytes_out
);
    localparam int FILL_WIDTH = OFFSET_WIDTH + 1;
    localparam int REM_WIDTH  = LENGTH_WIDTH + 1;

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_COPY} state_t;

    state_t                  state_q, state_d;
    logic [7:0]              out_byte_q, out_byte_d;
    logic                    out_valid_q, out_valid_d;
    logic [REM_WIDTH-1:0]    remaining_q, remaining_d;
    logic [OFFSET_WIDTH-1:0] offset_q, offset_d;
    logic [OFFSET_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [FILL_WIDTH-1:0]   fill_q, fill_d;
    logic [COUNT_WIDTH-1:0]  bytes_q, bytes_d;
    logic                    error_q, error_d;
    logic                    ready_en_q, ready_en_d;

    logic [7:0]              history_mem [HISTORY_DEPTH];

    logic                    accept_s, last_s, in_ready_s, take_s, start_s;
    logic [OFFSET_WIDTH-1:0] item_offset_s;
    logic [LENGTH_WIDTH-1:0] item_length_s;
    logic [OFFSET_WIDTH-1:0] src_new_s, src_copy_s;
    logic [7:0]              byte_new_s, byte_copy_s;

    assign item_offset_s = data_in[OFFSET_WIDTH-1:0];
    assign item_length_s = data_in[DATA_WIDTH-1:OFFSET_WIDTH];
    assign accept_s      = out_valid_q & out_ready;
    assign last_s        = (state_q == S_EMIT) ||
                           ((state_q == S_COPY) && (remaining_q == REM_WIDTH'(1)));
    assign in_ready_s    = ready_en_q & ((state_q == S_IDLE) | (accept_s & last_s));
    assign take_s        = in_valid & in_ready_s;
    assign start_s       = block_start & (state_q == S_IDLE);
    assign ready_en_d    = 1'b1;

    // The byte being written this edge is not yet in memory, so O=1 reads forward it.
    assign src_new_s   = wr_ptr_d - item_offset_s;
    assign src_copy_s  = wr_ptr_d - offset_q;
    assign byte_new_s  = (accept_s && (src_new_s == wr_ptr_q)) ? out_byte_q : history_mem[src_new_s];
    assign byte_copy_s = (accept_s && (src_copy_s == wr_ptr_q)) ? out_byte_q : history_mem[src_copy_s];

    // Window pointer, saturating fill and output count, all moving on an output accept.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        fill_d   = fill_q;
        bytes_d  = bytes_q;
        if (start_s) begin
            wr_ptr_d = '0;
            fill_d   = '0;
            bytes_d  = '0;
        end else if (accept_s) begin
            wr_ptr_d = wr_ptr_q + OFFSET_WIDTH'(1);
            fill_d   = (fill_q == FILL_WIDTH'(HISTORY_DEPTH)) ? fill_q : fill_q + FILL_WIDTH'(1);
            bytes_d  = bytes_q + COUNT_WIDTH'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end
    end

    // Next state and output byte selection.
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_byte_d  = out_byte_q;
        remaining_d = remaining_q;
        offset_d    = offset_q;
        error_d     = start_s ? 1'b0 : error_q;
        if (take_s) begin
            if (!control_word_in) begin
                state_d     = S_EMIT;
                out_valid_d = 1'b1;
                out_byte_d  = data_in[7:0];
            end else if ((item_offset_s == '0) || ({1'b0, item_offset_s} > fill_d)) begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                error_d     = 1'b1;
            end else begin
                state_d     = S_COPY;
                out_valid_d = 1'b1;
                out_byte_d  = byte_new_s;
                remaining_d = {1'b0, item_length_s} + REM_WIDTH'(1);
                offset_d    = item_offset_s;
            end
        end else if (accept_s && last_s) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
        end else if (accept_s) begin
            remaining_d = remaining_q - REM_WIDTH'(1);
            out_byte_d  = byte_copy_s;
        end else begin
            state_d = state_q;
        end
    end

    // Control and datapath registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            out_byte_q  <= 8'h00;
            remaining_q <= '0;
            offset_q    <= '0;
            wr_ptr_q    <= '0;
            fill_q      <= '0;
            bytes_q     <= '0;
            error_q     <= 1'b0;
            ready_en_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_byte_q  <= out_byte_d;
            remaining_q <= remaining_d;
            offset_q    <= offset_d;
            wr_ptr_q    <= wr_ptr_d;
            fill_q      <= fill_d;
            bytes_q     <= bytes_d;
            error_q     <= error_d;
            ready_en_q  <= ready_en_d;
        end
    end

    // History window write of every accepted output byte.
    always_ff @(posedge clock) begin
        if (accept_s) begin
            history_mem[wr_ptr_q] <= out_byte_q;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_byte  = out_byte_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign error     = error_q;
    assign bytes_out = bytes_q;
endmodule
